pe_fp_sched: RTL and testbench
==============================

Name: pe_fp_sched

Overview:
- Schedules one PE_FP-style pooled-conv PE across a full output map.
- Walks filter index (outer), pooled output row, then pooled output column (inner).
- Emits window and weight fetch coordinates plus the PE enable. Samples the PE's 1-bit binarised result and pooling index after a fixed pipeline latency.
- Buffers results in a small FIFO with credit-based backpressure. Reports start/busy/done to the layer controller.

Parameters:
- OUT_H, 14, pooled output rows per filter
- OUT_W, 14, pooled output columns per filter
- N_FILTER, 64, number of filters (output channels)
- PE_LATENCY, 2, cycles from pe_in_en to valid pe_data_out/pe_pindex (>=1)
- PINDEX_WIDTH, 2, pooling index width (clog2(POOL_H*POOL_W))
- FIFO_DEPTH, PE_LATENCY+2, result FIFO depth (>= PE_LATENCY+1)
- RA_W, clog2(N_FILTER*OUT_H*OUT_W), result address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the layer completes
- filt_idx  out  clog2(N_FILTER)  filter for weight/norm_ref/s fetch
- win_row  out  clog2(OUT_H)  pooled row of the issued window
- win_col  out  clog2(OUT_W)  pooled column of the issued window
- pe_in_en  out  1  issue strobe to PE; coordinates valid in the same cycle
- pe_data_out  in  1  PE binarised output
- pe_pindex  in  PINDEX_WIDTH  PE pooling index
- res_valid  out  1  FIFO head valid
- res_data  out  1  result bit at FIFO head
- res_pindex  out  PINDEX_WIDTH  pooling index at FIFO head
- res_addr  out  RA_W  filt*OUT_H*OUT_W + row*OUT_W + col of head entry
- res_ready  in  1  consumer accepts head when res_valid&&res_ready

Behaviour:

Reset:
- State=IDLE; counters, in-flight tag pipe and FIFO cleared.
- busy=0, done=0, pe_in_en=0, res_valid=0; coordinate and res outputs = 0.
- rst mid-operation aborts immediately: no done pulse, all in-flight results discarded.

FSM:
- IDLE: start=1 -> RUN; filt/row/col zeroed. start in any other state is ignored.
- RUN: issue when inflight + fifo_count < FIFO_DEPTH. On the last issue (filt=N_FILTER-1, row=OUT_H-1, col=OUT_W-1) -> DRAIN.
- DRAIN: no issue. When inflight=0 and FIFO empty -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.

Issue:
- pe_in_en=1 for one cycle per window; filt_idx/win_row/win_col are valid in that cycle.
- Column increments every issue. At OUT_W-1 it wraps to 0 and row increments; at OUT_H-1 row wraps to 0 and filt increments. No wrap beyond the last filter.
- pe_in_en=0 whenever the credit check fails; coordinates hold.

Tag pipe:
- A PE_LATENCY-deep shift register carries {valid, res_addr}.
- At cycle t+PE_LATENCY the FIFO pushes {pe_data_out, pe_pindex, tag addr}.
- FIFO is first-word-fall-through, so res_valid rises at t+PE_LATENCY+1.
- Pipeline latency from issue to res_valid: PE_LATENCY+1 cycles (empty FIFO).

Counting and overflow:
- inflight counts tag-pipe valids.
- A push and a pop in the same cycle keep fifo_count unchanged.
- The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.

Throughput and ordering:
- With res_ready held at 1: one issue per cycle, no bubbles.
- Total cycles from start to done = N_FILTER*OUT_H*OUT_W + PE_LATENCY + 3.
- Results are delivered strictly in issue order.
- res outputs hold stable while res_valid=1 and res_ready=0.

Test Plan:
- OUT_H=2, OUT_W=2, N_FILTER=2, PE_LATENCY=2, res_ready=1, start pulse -> 8 pe_in_en pulses on consecutive cycles with (f,r,c) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)...; res_addr 0..7 in order; first res_valid 3 cycles after first issue; done 13 cycles after start, single cycle.
- PE model returns data=addr[0], pindex=addr[1:0] -> each res_data/res_pindex matches its res_addr.
- res_ready=0 from start -> exactly FIFO_DEPTH(4) issues, then pe_in_en stays 0. Raise res_ready -> issue resumes, no result lost or duplicated, order preserved.
- Random res_ready (50%) over a full 2x2x2 layer -> 8 results in order; busy high until done; no FIFO overflow assertion.
- start asserted during RUN and during DRAIN -> ignored; counters unaffected, exactly one done.
- rst asserted at the 5th issue -> next cycle busy=0, res_valid=0, pe_in_en=0, no done. A new start then yields a complete, correct 8-result layer.

Source files
------------

// File: rtl/pe_fp_sched.sv
// Scheduler for one pooled-conv PE: walks filter/row/col, tags in-flight windows,
// and buffers PE results in a first-word-fall-through FIFO under credit control.
module pe_fp_sched #(
    parameter int unsigned OUT_H        = 14,
    parameter int unsigned OUT_W        = 14,
    parameter int unsigned N_FILTER     = 64,
    parameter int unsigned PE_LATENCY   = 2,
    parameter int unsigned PINDEX_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH   = PE_LATENCY + 2,
    parameter int unsigned RA_W         = $clog2(N_FILTER * OUT_H * OUT_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N_FILTER)-1:0] filt_idx,
    output logic [$clog2(OUT_H)-1:0]    win_row,
    output logic [$clog2(OUT_W)-1:0]    win_col,
    output logic                        pe_in_en,
    input  logic                        pe_data_out,
    input  logic [PINDEX_WIDTH-1:0]     pe_pindex,
    output logic                        res_valid,
    output logic                        res_data,
    output logic [PINDEX_WIDTH-1:0]     res_pindex,
    output logic [RA_W-1:0]             res_addr,
    input  logic                        res_ready
);

    localparam int unsigned FW  = $clog2(N_FILTER);
    localparam int unsigned RW  = $clog2(OUT_H);
    localparam int unsigned CLW = $clog2(OUT_W);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW  = $clog2(PE_LATENCY + 1);
    localparam int unsigned SW  = CNW + 1;

    localparam logic [FW-1:0]  F_LAST = FW'(N_FILTER - 1);
    localparam logic [RW-1:0]  R_LAST = RW'(OUT_H - 1);
    localparam logic [CLW-1:0] C_LAST = CLW'(OUT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              issue_q, issue_d;
    logic [FW-1:0]     filt_q, filt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CLW-1:0]    col_q, col_d;
    logic [RA_W-1:0]   addr_q, addr_d;

    logic              tag_v_q [PE_LATENCY];
    logic              tag_v_d [PE_LATENCY];
    logic [RA_W-1:0]   tag_a_q [PE_LATENCY];
    logic [RA_W-1:0]   tag_a_d [PE_LATENCY];
    logic [IW-1:0]     inflight_q, inflight_d;

    logic              mem_dat_q [FIFO_DEPTH];
    logic [PINDEX_WIDTH-1:0] mem_pix_q [FIFO_DEPTH];
    logic [RA_W-1:0]   mem_adr_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CNW-1:0]    count_q, count_d;

    logic              push, pop, last_win;
    logic [SW-1:0]     credit_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push     = tag_v_q[PE_LATENCY-1];
        pop      = (count_q != '0) && res_ready;
        last_win = (filt_q == F_LAST) && (row_q == R_LAST) && (col_q == C_LAST);

        state_d = state_q;
        filt_d  = filt_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    filt_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (issue_q) begin
                    if (last_win) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (col_q == C_LAST) begin
                            col_d = '0;
                            if (row_q == R_LAST) begin
                                row_d  = '0;
                                filt_d = filt_q + 1'b1;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0 && count_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Occupancy as it will stand next cycle, so the registered issue strobe never oversubscribes the FIFO.
        credit_sum = SW'(inflight_q) + SW'(count_q) + SW'(issue_q) - SW'(pop);
        issue_d    = (state_d == S_RUN) && (credit_sum < SW'(FIFO_DEPTH));
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);

        inflight_d = inflight_q + IW'(issue_q) - IW'(push);
        tag_v_d[0] = issue_q;
        tag_a_d[0] = addr_q;
        for (int unsigned i = 1; i < PE_LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_a_d[i] = tag_a_q[i-1];
        end

        count_d = count_q + CNW'(push) - CNW'(pop);
        wr_d    = push ? ptr_inc(wr_q) : wr_q;
        rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            issue_q    <= 1'b0;
            filt_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            inflight_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < PE_LATENCY; i++) begin
                tag_v_q[i] <= 1'b0;
                tag_a_q[i] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat_q[i] <= 1'b0;
                mem_pix_q[i] <= '0;
                mem_adr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            issue_q    <= issue_d;
            filt_q     <= filt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            for (int unsigned i = 0; i < PE_LATENCY; i++) begin
                tag_v_q[i] <= tag_v_d[i];
                tag_a_q[i] <= tag_a_d[i];
            end
            if (push) begin
                mem_dat_q[wr_q] <= pe_data_out;
                mem_pix_q[wr_q] <= pe_pindex;
                mem_adr_q[wr_q] <= tag_a_q[PE_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) assert (count_q != CNW'(FIFO_DEPTH));
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_in_en   = issue_q;
    assign filt_idx   = filt_q;
    assign win_row    = row_q;
    assign win_col    = col_q;
    assign res_valid  = (count_q != '0);
    assign res_data   = mem_dat_q[rd_q];
    assign res_pindex = mem_pix_q[rd_q];
    assign res_addr   = mem_adr_q[rd_q];

endmodule

// File: tb/tb_pe_fp_sched.sv
// Directed bench for pe_fp_sched on a 2x2 map with 2 filters and a 2-cycle PE model.
module tb_pe_fp_sched;

    localparam int unsigned OH = 2, OW = 2, NF = 2, LAT = 2, PIW = 2, DEPTH = 4, RAW = 3;

    logic           clk = 1'b0;
    logic           rst, start, pe_data_out, res_ready;
    logic [PIW-1:0] pe_pindex;
    logic           busy, done, pe_in_en, res_valid, res_data;
    logic [0:0]     filt_idx, win_row, win_col;
    logic [PIW-1:0] res_pindex;
    logic [RAW-1:0] res_addr;

    pe_fp_sched #(
        .OUT_H(OH), .OUT_W(OW), .N_FILTER(NF), .PE_LATENCY(LAT),
        .PINDEX_WIDTH(PIW), .FIFO_DEPTH(DEPTH), .RA_W(RAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .filt_idx(filt_idx), .win_row(win_row), .win_col(win_col), .pe_in_en(pe_in_en),
        .pe_data_out(pe_data_out), .pe_pindex(pe_pindex),
        .res_valid(res_valid), .res_data(res_data), .res_pindex(res_pindex),
        .res_addr(res_addr), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, cyc = 0, t0 = 0;
    int issues, pops, dones, busy_cnt, first_issue, last_issue, first_rv, done_cyc, next_n;
    int exp_q[$];
    logic [2:0] p0_a = '0, p1_a = '0, cur_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        issues = 0; pops = 0; dones = 0; busy_cnt = 0; next_n = 0;
        first_issue = -1; last_issue = -1; first_rv = -1; done_cyc = -1;
        exp_q.delete();
    endtask

    // Observe the current cycle, advance one clock, then update the PE model.
    task automatic tick();
        int a;
        if (pe_in_en) begin
            chk("issue_in_range", 32'(next_n < 8), 1);
            chk("issue_filt", 32'(filt_idx), next_n / (OH * OW));
            chk("issue_row", 32'(win_row), (next_n / OW) % OH);
            chk("issue_col", 32'(win_col), next_n % OW);
            exp_q.push_back(next_n);
            next_n++;
            issues++;
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
        end
        if (res_valid && first_rv < 0) first_rv = cyc;
        if (res_valid && res_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                a = exp_q.pop_front();
                chk("res_addr", 32'(res_addr), a);
                chk("res_data", 32'(res_data), a % 2);
                chk("res_pindex", 32'(res_pindex), a % 4);
            end
            pops++;
        end
        if (done) begin dones++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        cur_a = {filt_idx, win_row, win_col};
        @(posedge clk);
        #1;
        p1_a = p0_a;
        p0_a = cur_a;
        pe_data_out = p1_a[0];
        pe_pindex   = p1_a[1:0];
        cyc++;
    endtask

    task automatic begin_layer();
        clear_stats();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit random_ready);
        for (int i = 0; i < budget && dones == 0; i++) begin
            if (random_ready) res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        res_ready = 1'b1;
        chk("done_seen", 32'(dones), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b1; pe_data_out = 1'b0; pe_pindex = '0;
        clear_stats();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pe_in_en", 32'(pe_in_en), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_filt", 32'(filt_idx), 0);
        chk("rst_row", 32'(win_row), 0);
        chk("rst_col", 32'(win_col), 0);
        chk("rst_res_addr", 32'(res_addr), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_pindex", 32'(res_pindex), 0);
        rst = 1'b0;
        tick();

        // Full layer, consumer always ready: timing and ordering.
        begin_layer();
        wait_done(100, 1'b0);
        chk("l1_first_issue_lat", first_issue - t0, 1);
        chk("l1_issue_span", last_issue - first_issue, 7);
        chk("l1_issues", issues, 8);
        chk("l1_first_rv_lat", first_rv - first_issue, 3);
        chk("l1_done_lat", done_cyc - t0, 13);
        chk("l1_pops", pops, 8);
        chk("l1_sb_empty", exp_q.size(), 0);
        chk("l1_busy_cycles", busy_cnt, 12);
        tick();
        chk("l1_done_single", 32'(done), 0);
        chk("l1_busy_after", 32'(busy), 0);

        // Consumer stalled from start: credit limit caps issues at the FIFO depth.
        res_ready = 1'b0;
        begin_layer();
        repeat (20) tick();
        chk("l2_stall_issues", issues, DEPTH);
        chk("l2_stall_no_issue", 32'(pe_in_en), 0);
        chk("l2_stall_valid", 32'(res_valid), 1);
        chk("l2_stall_head", 32'(res_addr), 0);
        chk("l2_stall_pops", pops, 0);
        res_ready = 1'b1;
        wait_done(100, 1'b0);
        chk("l2_issues", issues, 8);
        chk("l2_pops", pops, 8);
        chk("l2_sb_empty", exp_q.size(), 0);

        // Random backpressure.
        begin_layer();
        wait_done(400, 1'b1);
        chk("l3_issues", issues, 8);
        chk("l3_pops", pops, 8);
        chk("l3_sb_empty", exp_q.size(), 0);
        chk("l3_busy_cycles", busy_cnt, done_cyc - t0 - 1);

        // start re-asserted in RUN (cycles 3,4) and DRAIN (cycles 10,11).
        begin_layer();
        repeat (2) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        wait_done(100, 1'b0);
        chk("l4_issues", issues, 8);
        chk("l4_pops", pops, 8);
        chk("l4_done_lat", done_cyc - t0, 13);
        repeat (6) tick();
        chk("l4_single_done", dones, 1);
        chk("l4_idle_busy", 32'(busy), 0);
        chk("l4_no_restart", issues, 8);

        // Reset on the 5th issue aborts the layer.
        begin_layer();
        for (int i = 0; i < 20 && issues < 4; i++) tick();
        chk("l5_fifth_issue", 32'(pe_in_en), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("l5_rst_busy", 32'(busy), 0);
        chk("l5_rst_valid", 32'(res_valid), 0);
        chk("l5_rst_pe_in_en", 32'(pe_in_en), 0);
        chk("l5_rst_done", 32'(done), 0);
        repeat (10) tick();
        chk("l5_no_done", dones, 0);
        chk("l5_idle", 32'(busy), 0);
        begin_layer();
        wait_done(100, 1'b0);
        chk("l5_issues", issues, 8);
        chk("l5_pops", pops, 8);
        chk("l5_done_lat", done_cyc - t0, 13);
        chk("l5_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
